// File: rtl/program_memory_loader_pkg.sv
// Shared definitions for the program memory loader.
//   loader_state_e : frame-parser FSM states (3-bit encoding)
//   BytesPerWord   : bytes assembled into one program-memory word
//   LenBytes       : bytes in the frame length header
//   ByteCntW       : width of the byte-within-word counter
//   CsumInit       : checksum value at the start of a frame
//   word_addr()    : word index -> PC-compatible byte address
package program_memory_loader_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLenLo = 3'd1,
      StLenHi = 3'd2,
      StData  = 3'd3,
      StCsum  = 3'd4,
      StDone  = 3'd5,
      StError = 3'd6
   } loader_state_e;

   localparam int unsigned BytesPerWord = 4;
   localparam int unsigned LenBytes     = 2;
   localparam int unsigned ByteCntW     = $clog2(BytesPerWord);
   localparam logic [7:0]  CsumInit     = 8'h00;

   function automatic logic [31:0] word_addr(input logic [15:0] index);
      return {14'b0, index, 2'b00};
   endfunction

endpackage

// File: rtl/program_memory_loader_if.sv
// Byte link and program-memory write port of the loader.
//   start_i       : one-cycle pulse, begin a new frame
//   byte_valid_i  : byte_data_i holds a valid byte
//   byte_data_i   : incoming frame byte
//   byte_ready_o  : loader accepts a byte this cycle
//   mem_write_o   : one-cycle write strobe per assembled word
//   mem_address_o : byte address of the word being written
//   mem_data_o    : word being written
// Modports: master = host / memory side, slave = loader.
interface program_memory_loader_if;

   logic        start_i;
   logic        byte_valid_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o;
   logic        mem_write_o;
   logic [31:0] mem_address_o;
   logic [31:0] mem_data_o;

   modport master (
      output start_i,
      output byte_valid_i,
      output byte_data_i,
      input  byte_ready_o,
      input  mem_write_o,
      input  mem_address_o,
      input  mem_data_o
   );

   modport slave (
      input  start_i,
      input  byte_valid_i,
      input  byte_data_i,
      output byte_ready_o,
      output mem_write_o,
      output mem_address_o,
      output mem_data_o
   );

endinterface

// File: rtl/program_memory_loader_byte_to_word_assembler.sv
// Packs a byte stream into little-endian 32-bit words.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart word assembly (new frame)
//   byte_valid : byte_data is consumed this cycle
//   byte_data  : incoming byte
//   word_valid : this cycle's byte completes a word (combinational)
//   word_data  : the completed word, valid with word_valid
module program_memory_loader_byte_to_word_assembler
   import program_memory_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word_data
);

   logic [ByteCntW-1:0] byte_cnt_q;
   // Holds the first three bytes of a word; the fourth is taken straight from the input.
   logic [23:0]         shift_q;

   assign word_valid = byte_valid && (byte_cnt_q == ByteCntW'(BytesPerWord - 1));
   assign word_data  = {byte_data, shift_q};

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         byte_cnt_q <= '0;
         shift_q    <= '0;
      end else if (byte_valid) begin
         byte_cnt_q <= byte_cnt_q + ByteCntW'(1);
         shift_q    <= {byte_data, shift_q[23:8]};
      end
   end

endmodule

// File: rtl/program_memory_loader.sv
// Framed program-image loader: parses LEN_LO, LEN_HI, 4*N data bytes and an XOR
// checksum, writes the words to program memory from address 0 and holds the core
// in reset until a frame verifies.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : byte link + memory write port (slave modport)
//   cpu_reset_o : 1 = hold the core in reset
//   busy_o      : frame in progress
//   done_o      : last frame loaded and verified
//   error_o     : last frame rejected
module program_memory_loader
   import program_memory_loader_pkg::*;
#(
   parameter int unsigned PROGRAM_MEMORY_DEPTH = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   program_memory_loader_if.slave bus,
   output logic                   cpu_reset_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   error_o
);

   localparam logic [15:0] Depth16 = 16'(PROGRAM_MEMORY_DEPTH);

   loader_state_e state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [15:0]   word_index_q, word_index_d;
   logic [7:0]    csum_q, csum_d;
   logic          byte_ready_q, byte_ready_d;
   logic          mem_write_q, mem_write_d;
   logic [31:0]   mem_address_q, mem_address_d;
   logic [31:0]   mem_data_q, mem_data_d;
   logic          cpu_reset_q, cpu_reset_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;

   logic          byte_accept;
   logic          asm_clear;
   logic          word_valid;
   logic [31:0]   word_data;
   logic [15:0]   len_word;

   assign byte_accept = bus.byte_valid_i && byte_ready_q;
   assign len_word    = {bus.byte_data_i, len_q[7:0]};

   program_memory_loader_byte_to_word_assembler u_assembler (
      .clk        (clk),
      .reset      (reset),
      .clear      (asm_clear),
      .byte_valid (byte_accept && (state_q == StData)),
      .byte_data  (bus.byte_data_i),
      .word_valid (word_valid),
      .word_data  (word_data)
   );

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      word_index_d  = word_index_q;
      csum_d        = csum_q;
      mem_write_d   = 1'b0;
      mem_address_d = mem_address_q;
      mem_data_d    = mem_data_q;
      cpu_reset_d   = cpu_reset_q;
      busy_d        = busy_q;
      done_d        = done_q;
      error_d       = error_q;
      asm_clear     = 1'b0;

      case (state_q)
         StIdle, StDone, StError: begin
            // IDLE lets the core run; DONE has already released it; ERROR keeps it held.
            if (state_q == StIdle) cpu_reset_d = 1'b0;
            if (bus.start_i) begin
               state_d      = StLenLo;
               done_d       = 1'b0;
               error_d      = 1'b0;
               word_index_d = '0;
               csum_d       = CsumInit;
               cpu_reset_d  = 1'b1;
               busy_d       = 1'b1;
               asm_clear    = 1'b1;
            end
         end
         StLenLo: begin
            if (byte_accept) begin
               len_d   = {8'h00, bus.byte_data_i};
               csum_d  = csum_q ^ bus.byte_data_i;
               state_d = StLenHi;
            end
         end
         StLenHi: begin
            if (byte_accept) begin
               len_d  = len_word;
               csum_d = csum_q ^ bus.byte_data_i;
               if (len_word > Depth16) begin
                  state_d = StError;
                  error_d = 1'b1;
                  busy_d  = 1'b0;
               end else if (len_word == 16'd0) begin
                  state_d = StCsum;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (byte_accept) begin
               csum_d = csum_q ^ bus.byte_data_i;
               if (word_valid) begin
                  // Word is registered here and appears on the port in the next cycle.
                  mem_write_d   = 1'b1;
                  mem_address_d = word_addr(word_index_q);
                  mem_data_d    = word_data;
                  word_index_d  = word_index_q + 16'd1;
                  if (word_index_q + 16'd1 == len_q) state_d = StCsum;
               end
            end
         end
         StCsum: begin
            if (byte_accept) begin
               busy_d = 1'b0;
               if (bus.byte_data_i == csum_q) begin
                  state_d     = StDone;
                  done_d      = 1'b1;
                  cpu_reset_d = 1'b0;
               end else begin
                  state_d = StError;
                  error_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Registered ready: follows the state being entered so it aligns with state_q.
      byte_ready_d = (state_d == StLenLo) || (state_d == StLenHi) ||
                     (state_d == StData)  || (state_d == StCsum);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         len_q         <= '0;
         word_index_q  <= '0;
         csum_q        <= CsumInit;
         byte_ready_q  <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_address_q <= '0;
         mem_data_q    <= '0;
         cpu_reset_q   <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         word_index_q  <= word_index_d;
         csum_q        <= csum_d;
         byte_ready_q  <= byte_ready_d;
         mem_write_q   <= mem_write_d;
         mem_address_q <= mem_address_d;
         mem_data_q    <= mem_data_d;
         cpu_reset_q   <= cpu_reset_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
      end
   end

   assign bus.byte_ready_o  = byte_ready_q;
   assign bus.mem_write_o   = mem_write_q;
   assign bus.mem_address_o = mem_address_q;
   assign bus.mem_data_o    = mem_data_q;
   assign cpu_reset_o       = cpu_reset_q;
   assign busy_o            = busy_q;
   assign done_o            = done_q;
   assign error_o           = error_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader: a frame-level model predicts every
// output each cycle; literal checks pin the model on the known example frames.
module tb_program_memory_loader;

   localparam int Depth = 64;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic cpu_reset_o, busy_o, done_o, error_o;

   program_memory_loader_if bus ();

   program_memory_loader #(
      .PROGRAM_MEMORY_DEPTH (Depth)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .cpu_reset_o (cpu_reset_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .error_o     (error_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int n_writes = 0;
   bit cmp_en = 1'b0;

   // Model of the outputs expected in the current cycle.
   logic        m_ready, m_write_pulse, m_cpu_reset, m_busy, m_done, m_error;
   logic [31:0] m_addr, m_data, m_word;
   int          m_pos, m_n;
   logic [7:0]  m_xor;

   logic [7:0]  frame[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act === exp) passes = passes + 1;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   function automatic void model_reset();
      m_ready = 0; m_write_pulse = 0; m_addr = 0; m_data = 0;
      m_cpu_reset = 1; m_busy = 0; m_done = 0; m_error = 0;
   endfunction

   function automatic void model_start();
      m_done = 0; m_error = 0; m_cpu_reset = 1; m_busy = 1; m_ready = 1;
      m_pos = 0; m_n = 0; m_xor = 8'h00;
   endfunction

   function automatic void model_finish(input bit ok);
      m_busy = 0; m_ready = 0;
      if (ok) begin m_done = 1; m_cpu_reset = 0; end
      else m_error = 1;
   endfunction

   // Byte at frame position m_pos has just been accepted.
   function automatic void model_accept(input logic [7:0] b);
      int k;
      if (m_pos == 0) m_n = int'(b);
      else if (m_pos == 1) m_n = m_n + 256 * int'(b);
      if (m_pos >= 2 && m_pos < 2 + 4 * m_n) begin
         k = (m_pos - 2) % 4;
         m_word[8*k +: 8] = b;
         if (k == 3) begin
            m_write_pulse = 1;
            m_addr = 32'(((m_pos - 2) / 4) * 4);
            m_data = m_word;
         end
      end
      if (m_pos == 1 && m_n > Depth) model_finish(0);
      else if (m_pos == 2 + 4 * m_n) model_finish(b == m_xor);
      m_xor = m_xor ^ b;
      m_pos = m_pos + 1;
   endfunction

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      #1;
      if (cmp_en) begin
         check("byte_ready", 32'(bus.byte_ready_o), 32'(m_ready));
         check("mem_write", 32'(bus.mem_write_o), 32'(m_write_pulse));
         check("mem_address", bus.mem_address_o, m_addr);
         check("mem_data", bus.mem_data_o, m_data);
         check("cpu_reset", 32'(cpu_reset_o), 32'(m_cpu_reset));
         check("busy", 32'(busy_o), 32'(m_busy));
         check("done", 32'(done_o), 32'(m_done));
         check("error", 32'(error_o), 32'(m_error));
         if (bus.mem_write_o === 1'b1) n_writes = n_writes + 1;
         m_write_pulse = 0;
      end
   end

   task automatic do_reset(input int cycles);
      bus.byte_valid_i = 0;
      bus.start_i = 0;
      reset = 1;
      repeat (cycles) begin
         @(negedge clk);
         model_reset();
         cmp_en = 1;
      end
      reset = 0;
      @(negedge clk);
      m_cpu_reset = 0;
   endtask

   task automatic pulse_start();
      bus.start_i = 1;
      @(negedge clk);
      bus.start_i = 0;
      if (!m_busy) model_start();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      int t;
      bus.byte_valid_i = 0;
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      bus.byte_valid_i = 1;
      bus.byte_data_i = b;
      t = 0;
      while (bus.byte_ready_o !== 1'b1 && t < 100) begin
         @(negedge clk);
         t = t + 1;
      end
      if (t >= 100) begin
         check("accept_timeout", 32'(bus.byte_ready_o), 32'd1);
         bus.byte_valid_i = 0;
         return;
      end
      @(negedge clk);
      bus.byte_valid_i = 0;
      model_accept(b);
   endtask

   task automatic send_range(input int first, input int last, input int gap_max);
      for (int i = first; i <= last; i++) send_byte(frame[i], gap_max);
   endtask

   task automatic build_frame(input int n, input bit corrupt);
      logic [7:0] x, b;
      frame.delete();
      x = 8'h00;
      b = 8'(n);      frame.push_back(b); x = x ^ b;
      b = 8'(n >> 8); frame.push_back(b); x = x ^ b;
      for (int i = 0; i < 4 * n; i++) begin
         b = 8'($urandom);
         frame.push_back(b);
         x = x ^ b;
      end
      if (corrupt) x = x ^ 8'($urandom_range(255, 1));
      frame.push_back(x);
   endtask

   task automatic set_example();
      frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h33, 8'h01, 8'h21, 8'h00, 8'h17};
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      bus.start_i = 0;
      bus.byte_valid_i = 0;
      bus.byte_data_i = 8'h00;
      model_reset();

      // Reset state and release of the core.
      bus.byte_valid_i = 0;
      reset = 1;
      repeat (2) @(negedge clk);
      model_reset();
      cmp_en = 1;
      check("rst_cpu_reset", 32'(cpu_reset_o), 32'd1);
      check("rst_ready", 32'(bus.byte_ready_o), 32'd0);
      check("rst_addr", bus.mem_address_o, 32'd0);
      reset = 0;
      @(negedge clk);
      m_cpu_reset = 0;
      check("rel_cpu_reset", 32'(cpu_reset_o), 32'd0);

      // Example frame.
      w0 = n_writes;
      pulse_start();
      set_example();
      send_range(0, 10, 0);
      repeat (2) @(negedge clk);
      check("ex_done", 32'(done_o), 32'd1);
      check("ex_cpu_reset", 32'(cpu_reset_o), 32'd0);
      check("ex_writes", 32'(n_writes - w0), 32'd2);
      check("ex_last_addr", bus.mem_address_o, 32'h4);
      check("ex_last_data", bus.mem_data_o, 32'h0021_0133);

      // Bad checksum.
      w0 = n_writes;
      pulse_start();
      set_example();
      frame[10] = 8'h16;
      send_range(0, 10, 0);
      repeat (3) @(negedge clk);
      check("bad_error", 32'(error_o), 32'd1);
      check("bad_done", 32'(done_o), 32'd0);
      check("bad_cpu_reset", 32'(cpu_reset_o), 32'd1);
      check("bad_writes", 32'(n_writes - w0), 32'd2);

      // Oversize length.
      w0 = n_writes;
      pulse_start();
      frame = '{8'h41, 8'h00};
      send_range(0, 1, 0);
      repeat (3) @(negedge clk);
      check("big_error", 32'(error_o), 32'd1);
      check("big_ready", 32'(bus.byte_ready_o), 32'd0);
      check("big_writes", 32'(n_writes - w0), 32'd0);

      // Empty frame.
      w0 = n_writes;
      pulse_start();
      frame = '{8'h00, 8'h00, 8'h00};
      send_range(0, 2, 0);
      repeat (2) @(negedge clk);
      check("empty_done", 32'(done_o), 32'd1);
      check("empty_writes", 32'(n_writes - w0), 32'd0);

      // Example frame with random gaps.
      w0 = n_writes;
      pulse_start();
      set_example();
      send_range(0, 10, 4);
      repeat (2) @(negedge clk);
      check("gap_done", 32'(done_o), 32'd1);
      check("gap_writes", 32'(n_writes - w0), 32'd2);

      // Reset after the 5th data byte.
      w0 = n_writes;
      pulse_start();
      set_example();
      send_range(0, 6, 2);
      do_reset(1);
      repeat (8) @(negedge clk);
      check("abort_writes", 32'(n_writes - w0), 32'd1);
      check("abort_cpu_reset", 32'(cpu_reset_o), 32'd0);

      // start_i during DATA is ignored.
      w0 = n_writes;
      pulse_start();
      set_example();
      send_range(0, 3, 0);
      pulse_start();
      send_range(4, 10, 1);
      repeat (2) @(negedge clk);
      check("mid_start_done", 32'(done_o), 32'd1);
      check("mid_start_writes", 32'(n_writes - w0), 32'd2);

      // Full-depth frame.
      w0 = n_writes;
      pulse_start();
      build_frame(Depth, 0);
      send_range(0, frame.size() - 1, 0);
      repeat (2) @(negedge clk);
      check("full_done", 32'(done_o), 32'd1);
      check("full_writes", 32'(n_writes - w0), 32'(Depth));

      // Random frames.
      for (int f = 0; f < 20; f++) begin
         pulse_start();
         build_frame($urandom_range(8, 0), ($urandom_range(3, 0) == 0));
         send_range(0, frame.size() - 1, 3);
         repeat ($urandom_range(3, 1)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
